parity_scan_display: RTL and testbench
======================================

Name: parity_scan_display

Overview:
- Multi-channel successor to the single-digit switch-parity indicator.
- Splits the switch bus into NUM_DIGITS equal channels and computes a registered parity per channel.
- Drives a time-multiplexed, active-low 7-segment display: one digit per channel, 'O' glyph for odd parity, 'E' glyph for even.
- Sits between the board switch inputs and the 7-segment pins at top level.

Parameters:
- CH_WIDTH, 8, switch bits per channel (>=1).
- NUM_DIGITS, 4, channels, digits and anode lines (1..8).
- PRESCALE, 50000, clock cycles each digit stays lit (>=2).

Ports:
- clk_i, input, 1, system clock.
- rst_n_i, input, 1, reset, asynchronous, active-low.
- sw_i, input, NUM_DIGITS*CH_WIDTH, raw switches. Channel k = sw_i[k*CH_WIDTH +: CH_WIDTH].
- freeze_i, input, 1, synchronous; 1 = hold all parity registers.
- led7_seg_o, output, 8, segments {a,b,c,d,e,f,g,dp}, active-low, registered.
- led7_an_o, output, NUM_DIGITS, digit anodes, active-low, one-hot-low, registered; bit k = digit k.
- parity_o, output, NUM_DIGITS, registered parity per channel; 1 = odd.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values:
  - led7_an_o all 1s (all digits off).
  - led7_seg_o 8'hFF (blank).
  - parity_o 0.
  - Sync registers 0, prescaler 0, digit index 0.
- Input synchroniser: sw_i passes through 2 flip-flop stages (sync1, sync2) before use.
- Parity:
  - parity_q[k] <= XOR-reduce of channel k of sync2, on every edge where freeze_i=0.
  - When freeze_i=1, parity_q holds.
  - A sw_i change that meets setup before edge E appears on parity_o after edge E+2, i.e. 3-cycle latency.
- freeze_i is sampled raw, with no synchroniser; the source is assumed synchronous to clk_i.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - When the prescaler equals PRESCALE-1, digit index advances on the same edge: idx+1, or 0 when idx = NUM_DIGITS-1.
- Output register, updated every edge from the current idx and parity_q:
  - led7_an_o = all 1s except bit idx = 0.
  - led7_seg_o = 8'b00000011 ('O') if parity_q[idx]=1, else 8'b01100001 ('E').
  - Outputs therefore lag idx and parity_q by one cycle.
- Duty: each digit is lit exactly PRESCALE consecutive cycles per frame. Frame length = NUM_DIGITS*PRESCALE cycles.
- First edge after reset release: led7_an_o selects digit 0 with its glyph (even, so 'E').
- Reset asserted mid-frame: all state returns immediately, without waiting for a clock, to the reset values above. Scan restarts at digit 0.
- freeze_i never affects scanning. Only parity_q holds.
- NUM_DIGITS=1: idx stays 0, led7_an_o = 1'b0 after the first edge, prescaler still runs.

Optional Feature:
- Macro: GHOST_BLANK_EN.
- Defined:
  - On the cycle where the prescaler equals PRESCALE-1, the output register loads all 1s on led7_an_o and 8'hFF on led7_seg_o. This gives a 1-cycle blank before each digit change to suppress ghosting.
  - Each digit is lit PRESCALE-1 cycles, then blank for 1 cycle.
- Undefined: no blanking. Each digit is lit exactly PRESCALE cycles.

Test Plan (PRESCALE=4, NUM_DIGITS=4, CH_WIDTH=8 unless stated):
1. Reset, then release with sw_i=0 -> led7_an_o=4'b1111 and seg=8'hFF during reset. First edge after release: an=4'b1110, seg=8'b01100001. Digits 0,1,2,3 each lit 4 cycles, then wrap to digit 0.
2. sw_i=32'h00_07_01_03 held -> parity_o=4'b0110 after 3 edges. Digit 1 and digit 2 show 8'b00000011; digits 0 and 3 show 8'b01100001.
3. freeze_i=1, then sw_i changes 0 -> 32'h00000001 -> parity_o stays 0 and scanning continues. Deassert freeze_i -> parity_o=4'b0001 on the next edge.
4. Assert rst_n_i=0 while digit 2 is lit (mid-frame) -> outputs go to reset values asynchronously. After release, scan restarts at an=4'b1110.
5. With GHOST_BLANK_EN defined -> each frame shows 3 lit cycles then 1 cycle of an=4'b1111, seg=8'hFF per digit. Without the macro, no such blank cycle ever appears.
6. NUM_DIGITS=1, CH_WIDTH=8, sw_i=8'hFF -> an=1'b0 constantly after the first edge, seg=8'b01100001. Then sw_i=8'h7F -> seg=8'b00000011 after 4 edges.

Source files
------------

// File: rtl/parity_scan_display.sv
// rtl/parity_scan_display.sv - per-channel switch parity on a scanned active-low 7-segment display
//
// Purpose:
//   Splits the switch bus into NUM_DIGITS channels of CH_WIDTH bits. Each channel
//   goes through a two-flop synchroniser and then an XOR reduction, and the result
//   is held in a registered parity bit (1 = odd). One digit per channel is scanned
//   onto a shared segment bus. Odd parity shows 'O' and even parity shows 'E'.
//
// Ports:
//   clk_i       in   1                      system clock
//   rst_n_i     in   1                      asynchronous active-low reset
//   sw_i        in   NUM_DIGITS*CH_WIDTH    raw switches, channel k = sw_i[k*CH_WIDTH +: CH_WIDTH]
//   freeze_i    in   1                      synchronous hold of the parity registers
//   led7_seg_o  out  8                      {a,b,c,d,e,f,g,dp}, active-low, registered
//   led7_an_o   out  NUM_DIGITS             digit anodes, active-low one-hot, registered
//   parity_o    out  NUM_DIGITS             registered parity per channel
//
// Optional build macro:
//   GHOST_BLANK_EN - blanks the display for the last prescaler cycle of every digit.
//                    This suppresses ghosting at each digit change.

module parity_scan_display #(
  parameter int CH_WIDTH   = 8,
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_DIGITS*CH_WIDTH-1:0] sw_i,
  input  logic                           freeze_i,
  output logic [7:0]                     led7_seg_o,
  output logic [NUM_DIGITS-1:0]          led7_an_o,
  output logic [NUM_DIGITS-1:0]          parity_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_ODD   = 8'b00000011;
  localparam logic [7:0] SEG_EVEN  = 8'b01100001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [NUM_DIGITS*CH_WIDTH-1:0] r_sync1;
  logic [NUM_DIGITS*CH_WIDTH-1:0] r_sync2;
  logic [NUM_DIGITS-1:0]          r_parity;
  logic [PW-1:0]                  r_presc;
  logic [IW-1:0]                  r_idx;
  logic [NUM_DIGITS-1:0]          r_an;
  logic [7:0]                     r_seg;

  logic [NUM_DIGITS-1:0]          w_parity_next;
  logic [NUM_DIGITS-1:0]          w_sel_onehot;
  logic [NUM_DIGITS-1:0]          w_an_next;
  logic [7:0]                     w_seg_next;
  logic                           w_presc_last;
  logic                           w_sel_odd;

  // Two-stage synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_i;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_parity_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_parity_next[k] = ^r_sync2[k*CH_WIDTH +: CH_WIDTH];
    end
  end

  // freeze_i comes from logic on clk_i, so it is used without a synchroniser.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_parity <= '0;
    end else if (!freeze_i) begin
      r_parity <= w_parity_next;
    end
  end

  assign w_presc_last = (r_presc == PRESC_LAST);

  // Scan timing: the digit index steps on the same edge that wraps the prescaler.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_presc_last) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // The one-hot digit select is built by comparison rather than by indexing.
  // This keeps index widths consistent for any NUM_DIGITS, including 1.
  always_comb begin
    w_sel_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_sel_onehot[k] = (r_idx == IW'(k));
    end
  end

  assign w_sel_odd = |(r_parity & w_sel_onehot);

  always_comb begin
    w_an_next  = ~w_sel_onehot;
    w_seg_next = w_sel_odd ? SEG_ODD : SEG_EVEN;
`ifdef GHOST_BLANK_EN
    if (w_presc_last) begin
      w_an_next  = '1;
      w_seg_next = SEG_BLANK;
    end
`else
`endif
  end

  // The output register lags idx and parity by one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign led7_an_o  = r_an;
  assign led7_seg_o = r_seg;
  assign parity_o   = r_parity;

endmodule

// File: tb/tb_parity_scan_display.sv
// tb/tb_parity_scan_display.sv - scoreboard bench for parity_scan_display (4-digit and 1-digit builds)

module tb_parity_scan_display;

  localparam logic [7:0] SEG_O = 8'b00000011;
  localparam logic [7:0] SEG_E = 8'b01100001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic [31:0] sw0;
  logic [7:0]  sw1;
  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, par0;
  logic [0:0]  an1, par1;

  always #5 clk = ~clk;

  parity_scan_display #(.CH_WIDTH(8), .NUM_DIGITS(4), .PRESCALE(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .sw_i(sw0), .freeze_i(freeze),
    .led7_seg_o(seg0), .led7_an_o(an0), .parity_o(par0)
  );

  parity_scan_display #(.CH_WIDTH(8), .NUM_DIGITS(1), .PRESCALE(4)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .sw_i(sw1), .freeze_i(freeze),
    .led7_seg_o(seg1), .led7_an_o(an1), .parity_o(par1)
  );

  typedef struct {
    int         ep;
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] par;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int epoch  = 0;

  // Edges since the last reset release; cycle n is sampled after edge n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [3:0] exp_an(int nd, int n);
    logic [3:0] a;
    int d;
    a = (nd == 4) ? 4'hF : 4'h1;
`ifdef GHOST_BLANK_EN
    if (n % 4 == 0) return a;
`endif
    d = ((n - 1) / 4) % nd;
    a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic [7:0] exp_seg(int n, logic odd);
`ifdef GHOST_BLANK_EN
    if (n % 4 == 0) return 8'hFF;
`endif
    return odd ? SEG_O : SEG_E;
  endfunction

  task automatic push_reset(int dut);
    exp_t e;
    e.ep  = epoch;
    e.cyc = 0;
    e.an  = dut ? 4'h1 : 4'hF;
    e.seg = 8'hFF;
    e.par = 4'h0;
    if (dut != 0) q1.push_back(e); else q0.push_back(e);
  endtask

  // Expected parity is pb before cycle swc and pa from it on. The glyph follows one cycle later.
  task automatic push_range(int dut, int from, int to, logic [3:0] pb, logic [3:0] pa, int swc);
    int nd;
    nd = (dut != 0) ? 1 : 4;
    for (int n = from; n <= to; n++) begin
      exp_t e;
      logic [3:0] pprev;
      int d;
      e.ep  = epoch;
      e.cyc = n;
      e.par = (n >= swc) ? pa : pb;
      pprev = (n - 1 >= swc) ? pa : pb;
      d     = ((n - 1) / 4) % nd;
      e.an  = exp_an(nd, n);
      e.seg = exp_seg(n, pprev[d]);
      if (dut != 0) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic cmp(string name, exp_t e, logic [3:0] an, logic [7:0] seg, logic [3:0] par);
    checks++;
    if (an !== e.an || seg !== e.seg || par !== e.par) begin
      errors++;
      $display("FAIL %s ep%0d cyc%0d: got an=%b seg=%b par=%b, required an=%b seg=%b par=%b",
               name, e.ep, e.cyc, an, seg, par, e.an, e.seg, e.par);
    end
  endtask

  // Monitor: wakes away from the active edge and on reset assertion, and pops due entries.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    while (q0.size() > 0 && (q0[0].ep < epoch || (q0[0].ep == epoch && q0[0].cyc <= cyc))) begin
      me = q0.pop_front();
      if (me.ep == epoch && me.cyc == cyc) cmp("dut4", me, an0, seg0, par0);
      else begin
        checks++; errors++;
        $display("FAIL dut4 missed sample ep%0d cyc%0d, now ep%0d cyc%0d", me.ep, me.cyc, epoch, cyc);
      end
    end
    while (q1.size() > 0 && (q1[0].ep < epoch || (q1[0].ep == epoch && q1[0].cyc <= cyc))) begin
      me = q1.pop_front();
      if (me.ep == epoch && me.cyc == cyc) cmp("dut1", me, {3'b000, an1}, seg1, {3'b000, par1});
      else begin
        checks++; errors++;
        $display("FAIL dut1 missed sample ep%0d cyc%0d, now ep%0d cyc%0d", me.ep, me.cyc, epoch, cyc);
      end
    end
  end

  task automatic wait_drain(int limit);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain timeout: %0d/%0d entries pending, required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    int  c0;
    int  c1;
    bit  found;
    rst_n  = 1'b0;
    freeze = 1'b0;
    sw0    = 32'h0;
    sw1    = 8'hFF;
    epoch  = 1;
    push_reset(0);
    push_reset(1);
    repeat (3) @(posedge clk);

    // Reset release: digit 0 first, each digit held 4 cycles, then wrap.
    @(negedge clk);
    rst_n = 1'b1;
    push_range(0, 1, 17, 4'h0, 4'h0, 1000);
    push_range(1, 1, 8, 4'h0, 4'h0, 1000);
    wait_drain(40);

    // Mixed parities: 3-cycle latency on parity_o, one more cycle for the glyph.
    @(negedge clk);
    c0  = cyc;
    sw0 = 32'h00_07_01_03;
    push_range(0, c0 + 1, c0 + 20, 4'h0, 4'b0110, c0 + 3);
    wait_drain(40);

    // Back to zero, then freeze while the switches change.
    @(negedge clk);
    c0  = cyc;
    sw0 = 32'h0;
    push_range(0, c0 + 1, c0 + 6, 4'b0110, 4'h0, c0 + 3);
    wait_drain(20);
    @(negedge clk);
    c0     = cyc;
    freeze = 1'b1;
    @(negedge clk);
    sw0 = 32'h0000_0001;
    push_range(0, c0 + 2, c0 + 12, 4'h0, 4'h0, 1000);
    wait_drain(20);
    @(negedge clk);
    c1     = cyc;
    freeze = 1'b0;
    push_range(0, c1 + 1, c1 + 6, 4'h0, 4'b0001, c1 + 1);
    wait_drain(20);

    // Asynchronous reset while digit 2 is lit, checked before any further clock edge.
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      @(posedge clk);
      #2;
      if (cyc > 0 && ((cyc - 1) / 4) % 4 == 2) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL digit2 search: not found, required digit 2 within 24 cycles");
    end
    epoch = epoch + 1;
    push_reset(0);
    push_reset(1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_range(0, 1, 8, 4'h0, 4'b0001, 3);
    push_range(1, 1, 8, 4'h0, 4'h0, 1000);
    wait_drain(20);

    // Single-digit build: an stays low, glyph turns to 'O' four edges after 8'h7F.
    @(negedge clk);
    c0  = cyc;
    sw1 = 8'h7F;
    push_range(1, c0 + 1, c0 + 8, 4'h0, 4'h1, c0 + 3);
    wait_drain(20);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
